// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned   XLEN             = 32;
  localparam logic [31:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned   INSTR_BYTES      = 4;
  localparam logic [31:0]   NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_adder.sv
// Ripple-carry adder; the final carry is dropped so the sum wraps modulo 2^n.
module fetch_pc_unit_adder #(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] sum
);

  logic carry;

  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < int'(n); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// hands each instruction to decode over a valid/ready handshake.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [N-1:0]  if_pc,
  output logic [31:0]   if_instr
);

  fetch_state_e state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         squash_q, squash_d;
  logic         capture;
  logic [N-1:0] pc_plus4;
  logic [N-1:0] redirect_aligned;
  logic [N-1:0] if_pc_q;
  logic [31:0]  if_instr_q;

  fetch_pc_unit_adder #(
    .n (N)
  ) u_pc_adder (
    .a   (pc_q),
    .b   (N'(INSTR_BYTES)),
    .sum (pc_plus4)
  );

  assign redirect_aligned = redirect_pc & ~(N'(INSTR_BYTES - 1));

  // Next-state, PC/squash update and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    squash_d  = squash_q;
    capture   = 1'b0;
    imem_req  = 1'b0;
    imem_addr = '0;
    if_valid  = 1'b0;

    unique case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        state_d   = FETCH_WAIT;
        if (redirect_valid) squash_d = 1'b1;
      end
      FETCH_WAIT: begin
        if (redirect_valid) begin
          if (imem_rvalid) begin
            squash_d = 1'b0;
            state_d  = FETCH_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = FETCH_REQ;
          end else begin
            capture = 1'b1;
            pc_d    = pc_plus4;
            state_d = FETCH_HOLD;
          end
        end
      end
      FETCH_HOLD: begin
        if_valid = 1'b1;
        if (redirect_valid || if_ready) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_IDLE;
    endcase

    // A redirect always retargets the PC, whatever else happens this cycle.
    if (redirect_valid) pc_d = redirect_aligned;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      squash_q   <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      if (capture) begin
        if_pc_q    <= pc_q;
        if_instr_q <= imem_rdata;
      end
    end
  end

  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a latency-configurable memory that
// returns the request address as the instruction word.
module tb_fetch_pc_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = NOP_INSTR;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  int          mem_lat  = 1;
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory ignores reset; a response appears mem_lat cycles after the request cycle ends.
  task automatic mem_update();
    imem_rvalid = 1'b0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr;
        mem_pend    = 1'b0;
      end
    end
    if (imem_req) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_lat + 1;
      mem_addr = imem_addr;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    mem_update();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!if_valid && n < 40);
    chk({tag, "_valid_seen"}, 32'(if_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!imem_req && n < 40);
    chk({tag, "_req_seen"}, 32'(imem_req), 32'd1);
  endtask

  // Leaves the bench in the first REQ cycle after reset release.
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int last;
    int rc;

    // Reset values
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t1_first_req", 32'(imem_req), 32'd1);
    chk("t1_first_addr", imem_addr, 32'h0);

    // Sequential fetch, 1-cycle memory, decode always ready
    last = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid("t1");
      chk("t1_pc", if_pc, 32'(i * 4));
      chk("t1_instr", if_instr, 32'(i * 4));
      if (i > 0) chk("t1_gap", 32'(cyc - last), 32'd4);
      last = cyc;
    end

    // Backpressure in HOLD
    mem_lat = 1;
    if_ready = 1'b1;
    do_reset();
    wait_valid("t2a");
    chk("t2_pc0", if_pc, 32'h0);
    tick();
    if_ready = 1'b0;
    wait_valid("t2b");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 32'(if_valid), 32'd1);
      chk("t2_hold_pc", if_pc, 32'h4);
      chk("t2_hold_instr", if_instr, 32'h4);
      chk("t2_hold_noreq", 32'(imem_req), 32'd0);
    end
    if_ready = 1'b1;
    tick();
    chk("t2_after_req", 32'(imem_req), 32'd1);
    chk("t2_after_addr", imem_addr, 32'h8);
    chk("t2_after_valid", 32'(if_valid), 32'd0);

    // Redirect in WAIT with 3-cycle memory: stale response dropped
    mem_lat = 3;
    do_reset();
    rc = cyc;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    wait_req("t3");
    chk("t3_req_cycle", 32'(cyc - rc), 32'd5);
    chk("t3_addr", imem_addr, 32'h100);
    wait_valid("t3");
    chk("t3_pc", if_pc, 32'h100);
    chk("t3_instr", if_instr, 32'h100);

    // Redirect coinciding with the response
    mem_lat = 1;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_valid", 32'(if_valid), 32'd0);
    wait_valid("t4");
    chk("t4_pc", if_pc, 32'h200);
    chk("t4_instr", if_instr, 32'h200);

    // Redirect in REQ to the top word, then PC wraps to zero
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_req("t5a");
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    wait_valid("t5");
    chk("t5_pc", if_pc, 32'hFFFF_FFFC);
    wait_req("t5b");
    chk("t5_addr_wrap", imem_addr, 32'h0);

    // Redirect in HOLD beats if_ready
    do_reset();
    wait_valid("t6");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    chk("t6_valid", 32'(if_valid), 32'd0);
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", imem_addr, 32'h40);

    // Reset asserted in WAIT; response lands in IDLE and is ignored
    do_reset();
    wait_valid("t7a");
    wait_req("t7a");
    chk("t7_pre_addr", imem_addr, 32'h4);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7_idle_valid", 32'(if_valid), 32'd0);
    chk("t7_idle_req", 32'(imem_req), 32'd0);
    tick();
    chk("t7_req", 32'(imem_req), 32'd1);
    chk("t7_addr", imem_addr, 32'h0);
    tick();
    chk("t7_wait1_valid", 32'(if_valid), 32'd0);
    tick();
    chk("t7_wait2_valid", 32'(if_valid), 32'd0);
    tick();
    chk("t7_hold_valid", 32'(if_valid), 32'd1);
    chk("t7_hold_pc", if_pc, 32'h0);
    chk("t7_hold_instr", if_instr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the single-cycle/multicycle datapath.
- Owns the program counter and issues one instruction-memory request at a time.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Feeds the 32-bit ripple adder, which produces PC+4, and consumes that adder's sum as the sequential next PC. Branch/jump redirects override the sequential PC.

Parameters:
- N, 32, datapath/address width; passed unchanged to the adder instance.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  N  target address; bits [1:0] are forced to 0 internally
- imem_req  output  1  one-cycle request strobe
- imem_addr  output  N  request address, valid while imem_req=1
- imem_rvalid  input  1  response valid
- imem_rdata  input  32  instruction word
- if_valid  output  1  if_pc/if_instr hold a valid instruction
- if_ready  input  1  decode accepts this cycle
- if_pc  output  N  PC of the presented instruction
- if_instr  output  32  presented instruction

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pc_q=RESET_PC, state=IDLE, squash=0.
  - imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0.
  - Reset applies mid-transaction too: any in-flight response is abandoned.
- States: IDLE, REQ, WAIT, HOLD. All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- IDLE: outputs idle; next state REQ. An imem_rvalid seen in IDLE is ignored.
- REQ:
  - imem_req=1 and imem_addr=pc_q for exactly one cycle; next state WAIT.
- WAIT:
  - imem_req=0. Memory latency is 1 or more cycles; only one request is ever outstanding.
  - On imem_rvalid with squash=0: capture if_pc=pc_q and if_instr=imem_rdata; pc_q <= adder sum (pc_q+4); next state HOLD.
  - On imem_rvalid with squash=1: drop the data, clear squash; next state REQ.
- HOLD:
  - if_valid=1; if_pc and if_instr stay stable until accepted.
  - On if_valid && if_ready: if_valid deasserts next cycle; next state REQ.
- Minimum cadence is 4 cycles per instruction with 1-cycle memory and if_ready held high.
- PC arithmetic:
  - PC+4 comes from one adder instance with a = pc_q and b = 32'd4.
  - Carry-out is discarded, so 32'hFFFF_FFFC+4 wraps to 0.
- redirect_valid takes priority over all other events in the same cycle. It always sets pc_q <= {redirect_pc[N-1:2],2'b00}.
  - In IDLE: next state REQ.
  - In REQ (request already issued): set squash=1; next state WAIT.
  - In WAIT without imem_rvalid: set squash=1; stay in WAIT.
  - In WAIT with imem_rvalid the same cycle: drop the response; next state REQ with squash=0.
  - In HOLD: if_valid=0 next cycle, even if if_ready was high that cycle (redirect wins, the instruction is not handed over); next state REQ.
- Back-to-back redirects: the last one wins, and squash stays set until the stale response returns.
- A redirect while squash=1 in WAIT updates pc_q only.

Decomposition:
- Shared package (cpu_pkg):
  - RESET_PC default and INSTR_BYTES=4.
  - State enumeration constants FETCH_IDLE/REQ/WAIT/HOLD (2-bit encoding).
  - NOP_INSTR constant, used by benches.
- Sub-module: the existing adder, instantiated with n=N, produces pc_q+4. No other sub-modules.

Test Plan:
- Reset, then 1-cycle memory returning the address as data, if_ready=1 → if_pc sequence 0x0,0x4,0x8,0xC with if_instr equal to if_pc; if_valid pulses every 4 cycles.
- Hold if_ready=0 for 5 cycles while in HOLD with if_pc=0x4 → if_valid, if_pc and if_instr are stable; no imem_req until accepted.
- redirect_valid with redirect_pc=0x103 while in WAIT (3-cycle memory) → stale response dropped; next imem_addr=0x100; next if_pc=0x100.
- redirect_valid and imem_rvalid in the same WAIT cycle, redirect_pc=0x200 → response never appears on if_instr; the next cycle is REQ with imem_addr=0x200.
- pc_q forced via redirect to 0xFFFF_FFFC → fetched if_pc=0xFFFF_FFFC, then the next imem_addr=0x0000_0000.
- rst_n=0 asserted in WAIT, with imem_rvalid arriving during the following IDLE → response ignored; first post-reset imem_addr=RESET_PC; if_valid stays 0 until that response arrives.
